jtkiwi_obj_draw: RTL

Object tile drawing engine for the SETA object processor. Accepts one draw request per 16-pixel sprite row from the object scanner, fetches the row's two 32-bit graphics words from ROM and writes the non-transparent pixels, tagged with palette, into the object line buffer. It is the responder side of the scanner's draw/busy handshake.

---
 rtl/jtkiwi_obj_pkg.sv | 25 ++
 rtl/jtkiwi_obj_draw_if.sv | 29 ++
 rtl/jtkiwi_obj_shifter.sv | 27 ++
 rtl/jtkiwi_obj_draw.sv | 122 ++++++++++++
 4 files changed

// File: rtl/jtkiwi_obj_pkg.sv
// Shared constants and state encoding for the SETA object tile drawing engine.
package jtkiwi_obj_pkg;

   localparam int VFLIP    = 15;
   localparam int HFLIP    = 14;
   localparam int PAL_HI   = 13;
   localparam int PAL_LO   = 9;
   localparam int TILE_W   = 16;
   localparam int PXL_BITS = 4;
   localparam int HALF_PXL = TILE_W / 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH0,
      ST_DRAW0,
      ST_FETCH1,
      ST_DRAW1
   } state_t;

   // ROM word address of one half of a tile row
   function automatic logic [17:0] rom_word(logic [12:0] code, logic [3:0] yr, logic half);
      return {code, yr, half};
   endfunction

endpackage

// File: rtl/jtkiwi_obj_draw_if.sv
// Scanner request, graphics ROM and line buffer signals of the object drawing engine.
interface jtkiwi_obj_draw_if;

   logic        draw;
   logic        busy;
   logic [15:0] code;
   logic [15:0] attr;
   logic [8:0]  xpos;
   logic [3:0]  ysub;
   logic        flip;
   logic [17:0] rom_addr;
   logic        rom_cs;
   logic        rom_ok;
   logic [31:0] rom_data;
   logic [8:0]  buf_addr;
   logic        buf_we;
   logic [8:0]  buf_din;

   modport master (
      output draw, code, attr, xpos, ysub, flip, rom_ok, rom_data,
      input  busy, rom_addr, rom_cs, buf_addr, buf_we, buf_din
   );

   modport slave (
      input  draw, code, attr, xpos, ysub, flip, rom_ok, rom_data,
      output busy, rom_addr, rom_cs, buf_addr, buf_we, buf_din
   );

endinterface

// File: rtl/jtkiwi_obj_shifter.sv
// 32-bit graphics word shifter: presents one 4-bit pixel per cycle in either direction.
module jtkiwi_obj_shifter
   import jtkiwi_obj_pkg::*;
(
   input  logic                clk,
   input  logic                load,
   input  logic                shift,
   input  logic                dir,
   input  logic [31:0]         din,
   output logic [PXL_BITS-1:0] pxl,
   output logic                blank
);

   logic [31:0] sr;

   // dir=1 walks from the low nibble upwards (horizontally mirrored row)
   always_ff @(posedge clk) begin
      if (load)
         sr <= din;
      else if (shift)
         sr <= dir ? {4'h0, sr[31:4]} : {sr[27:0], 4'h0};
   end

   assign pxl   = dir ? sr[3:0] : sr[31:28];
   assign blank = (pxl == '0);

endmodule

// File: rtl/jtkiwi_obj_draw.sv
// Object row drawing engine: fetches two ROM words per 16-pixel row and writes
// the opaque pixels, tagged with palette, into the object line buffer.
module jtkiwi_obj_draw
   import jtkiwi_obj_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   jtkiwi_obj_draw_if.slave   bus
);

   state_t        st;
   logic [12:0]   code_l;
   logic [3:0]    yr_l;
   logic          hf_l;
   logic [4:0]    pal_l;
   logic [8:0]    col;
   logic [2:0]    cnt;
   logic          addr_new;
   logic          busy_r;
   logic          cs_r;
   logic [17:0]   addr_r;
   logic [3:0]    yr_now;
   logic          hf_now;
   logic          accept;
   logic          drawing;
   logic          sh_load;
   logic [PXL_BITS-1:0] pxl;
   logic          blank;
   logic          unused_bits;

   assign unused_bits = ^{bus.code[15:13], bus.attr[PAL_LO-1:0]};

   assign yr_now  = bus.ysub ^ {4{bus.attr[VFLIP]}};
   assign hf_now  = bus.attr[HFLIP] ^ bus.flip;
   // rom_ok is only trusted once the address has been stable for a cycle
   assign accept  = bus.rom_ok & ~addr_new;
   assign drawing = (st == ST_DRAW0) || (st == ST_DRAW1);
   assign sh_load = ((st == ST_FETCH0) || (st == ST_FETCH1)) & accept;

   jtkiwi_obj_shifter u_shifter (
      .clk   (clk),
      .load  (sh_load),
      .shift (drawing),
      .dir   (hf_l),
      .din   (bus.rom_data),
      .pxl   (pxl),
      .blank (blank)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= ST_IDLE;
         code_l   <= '0;
         yr_l     <= '0;
         hf_l     <= 1'b0;
         pal_l    <= '0;
         col      <= '0;
         cnt      <= '0;
         addr_new <= 1'b0;
         busy_r   <= 1'b0;
         cs_r     <= 1'b0;
         addr_r   <= '0;
      end else begin
         addr_new <= 1'b0;
         case (st)
            ST_IDLE: begin
               if (bus.draw && !busy_r) begin
                  code_l   <= bus.code[12:0];
                  yr_l     <= yr_now;
                  hf_l     <= hf_now;
                  pal_l    <= bus.attr[PAL_HI:PAL_LO];
                  col      <= bus.xpos;
                  addr_r   <= rom_word(bus.code[12:0], yr_now, hf_now);
                  addr_new <= 1'b1;
                  busy_r   <= 1'b1;
                  cs_r     <= 1'b1;
                  st       <= ST_FETCH0;
               end
            end
            ST_FETCH0: begin
               // Switch to the second word now so it has aged by the time FETCH1 starts
               if (accept) begin
                  addr_r   <= rom_word(code_l, yr_l, ~hf_l);
                  addr_new <= 1'b1;
                  cnt      <= '0;
                  st       <= ST_DRAW0;
               end
            end
            ST_DRAW0: begin
               cnt <= cnt + 3'd1;
               col <= col + 9'd1;
               if (cnt == 3'(HALF_PXL - 1))
                  st <= ST_FETCH1;
            end
            ST_FETCH1: begin
               if (accept) begin
                  cs_r <= 1'b0;
                  cnt  <= '0;
                  st   <= ST_DRAW1;
               end
            end
            ST_DRAW1: begin
               cnt <= cnt + 3'd1;
               col <= col + 9'd1;
               if (cnt == 3'(HALF_PXL - 1)) begin
                  busy_r <= 1'b0;
                  st     <= ST_IDLE;
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_r;
   assign bus.rom_cs   = cs_r;
   assign bus.rom_addr = addr_r;
   assign bus.buf_addr = col;
   assign bus.buf_we   = drawing & ~blank;
   assign bus.buf_din  = drawing ? {pal_l, pxl} : '0;

endmodule
